dfr_batch_ctrl: RTL and testbench

// - Parametrised successor controller for the DFR accelerator: buffers RX samples in an internal FIFO.
// - Launches a DFR run only once a full batch of samples is buffered.
// - Feeds the batch to the DFR core on its next-sample requests, then waits for dfr_done.
// - Sits between the bladeRF RX sample path and the DFR core. Adds batching, status flags and a batch counter.

---
 rtl/dfr_batch_ctrl_pkg.sv | 21 ++
 rtl/dfr_batch_ctrl_if.sv | 42 ++++
 rtl/dfr_batch_ctrl_fifo.sv | 68 ++++++
 rtl/dfr_batch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dfr_batch_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dfr_batch_ctrl_pkg.sv
// Shared definitions for the DFR batch controller.
// State encoding and a constant clog2 helper.
package dfr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } dfr_state_e;

    function automatic int dfr_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dfr_batch_ctrl_if.sv
// Sample-path bundle between the RX side, the batch controller and the DFR core.
// The controller uses the slave modport; the environment drives the master side.
interface dfr_batch_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 7
);

    logic              rx_sample_valid;
    logic [DATA_W-1:0] rx_sample_data;
    logic              rx_sample_fifo_wfull;
    logic [CNT_W-1:0]  rx_sample_fifo_count;
    logic              dfr_start;
    logic              dfr_next_sample;
    logic [DATA_W-1:0] dfr_sample_data;
    logic              dfr_sample_valid;
    logic              dfr_done;

    modport slave (
        input  rx_sample_valid,
        input  rx_sample_data,
        input  dfr_next_sample,
        input  dfr_done,
        output rx_sample_fifo_wfull,
        output rx_sample_fifo_count,
        output dfr_start,
        output dfr_sample_data,
        output dfr_sample_valid
    );

    modport master (
        output rx_sample_valid,
        output rx_sample_data,
        output dfr_next_sample,
        output dfr_done,
        input  rx_sample_fifo_wfull,
        input  rx_sample_fifo_count,
        input  dfr_start,
        input  dfr_sample_data,
        input  dfr_sample_valid
    );

endinterface

// File: rtl/dfr_batch_ctrl_fifo.sv
// Synchronous first-word-fall-through sample FIFO (module dfr_sample_fifo).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module dfr_sample_fifo
    import dfr_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int AW = dfr_clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Head is forced to zero when empty so stale RAM never reaches the core.
    assign data_o = empty_o ? '0 : mem[rptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dfr_batch_ctrl.sv
// DFR batch controller: buffers RX samples and launches a DFR run per full batch.
// Optional RUN watchdog is enabled by defining DFR_BATCH_TIMEOUT_EN.
module dfr_batch_ctrl
    import dfr_pkg::*;
#(
    parameter int   DATA_W         = 16,
    parameter int   FIFO_DEPTH     = 64,
    localparam int  CNT_W          = dfr_clog2(FIFO_DEPTH) + 1,
    parameter int   BCNT_W         = 16,
    parameter int   TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  batch_len,
    dfr_batch_if.slave        bus,
    output logic              batch_done,
    output logic              busy,
    output logic              overflow,
    output logic              underflow,
    output logic              timeout,
    output logic [BCNT_W-1:0] batch_count
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("dfr_batch_ctrl: bad FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    dfr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  popped_q, popped_d;
    logic [BCNT_W-1:0] bcnt_q;
    logic              ovf_q;
    logic              unf_q;
    logic [CNT_W-1:0]  eff_len;
    logic              launch;
    logic              wd_hit;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              sample_valid;
    logic              pop;

    dfr_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.rx_sample_valid),
        .data_i  (bus.rx_sample_data),
        .pop_i   (pop),
        .data_o  (bus.dfr_sample_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        eff_len = batch_len;
        if (batch_len == '0) begin
            eff_len = CNT_ONE;
        end else if (batch_len > CNT_DEPTH) begin
            eff_len = CNT_DEPTH;
        end
    end

    assign launch       = enable && (fifo_count >= eff_len);
    assign sample_valid = (state_q == ST_RUN) && !fifo_empty &&
                          (popped_q < len_q);
    assign pop          = bus.dfr_next_sample && sample_valid;

    assign bus.dfr_sample_valid     = sample_valid;
    assign bus.rx_sample_fifo_wfull = fifo_full;
    assign bus.rx_sample_fifo_count = fifo_count;
    assign busy        = (state_q != ST_IDLE);
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign batch_count = bcnt_q;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        popped_d      = popped_q;
        bus.dfr_start = 1'b0;
        batch_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_START;
                    len_d   = eff_len;
                end
            end
            ST_START: begin
                bus.dfr_start = 1'b1;
                popped_d      = '0;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (pop) begin
                    popped_d = popped_q + CNT_ONE;
                end
                if (bus.dfr_done || wd_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                batch_done = 1'b1;
                // Back-to-back batches skip IDLE to restart one cycle sooner.
                if (launch) begin
                    state_d = ST_START;
                    len_d   = eff_len;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_q    <= CNT_ONE;
            popped_q <= '0;
            bcnt_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            popped_q <= popped_d;
            if (state_q == ST_DONE) begin
                bcnt_q <= bcnt_q + BCNT_ONE;
            end
            if (bus.rx_sample_valid && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (state_q == ST_RUN && bus.dfr_next_sample && !sample_valid) begin
                unf_q <= 1'b1;
            end
        end
    end

`ifdef DFR_BATCH_TIMEOUT_EN
    localparam int WD_W = dfr_clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_q;
    logic            tmo_q;

    // Counter idles at zero outside RUN, so each run starts from a clean count.
    assign wd_hit  = (state_q == ST_RUN) && !bus.dfr_done && (wd_q == WD_LAST);
    assign timeout = tmo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                wd_q <= wd_q + WD_ONE;
            end else begin
                wd_q <= '0;
            end
            if (wd_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dfr_batch_ctrl.sv
// Directed bench for dfr_batch_ctrl (FIFO_DEPTH=64, TIMEOUT_CYCLES=100).
module tb_dfr_batch_ctrl;

    localparam int DW   = 16;
    localparam int CW   = 7;
    localparam int BW   = 16;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] batch_len = 7'd4;
    logic          batch_done;
    logic          busy;
    logic          overflow;
    logic          underflow;
    logic          timeout;
    logic [BW-1:0] batch_count;

    int total = 0;
    int bad   = 0;

    dfr_batch_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    dfr_batch_ctrl #(
        .DATA_W         (DW),
        .FIFO_DEPTH     (64),
        .BCNT_W         (BW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .batch_len   (batch_len),
        .bus         (bus),
        .batch_done  (batch_done),
        .busy        (busy),
        .overflow    (overflow),
        .underflow   (underflow),
        .timeout     (timeout),
        .batch_count (batch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.rx_sample_valid = 1'b1;
        bus.rx_sample_data  = d;
        tick();
        bus.rx_sample_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.rx_sample_valid = 1'b0;
        bus.rx_sample_data  = '0;
        bus.dfr_next_sample = 1'b0;
        bus.dfr_done        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_count", bus.rx_sample_fifo_count, 0);
        chk("rst_full", bus.rx_sample_fifo_wfull, 0);
        chk("rst_start", bus.dfr_start, 0);
        chk("rst_svalid", bus.dfr_sample_valid, 0);
        chk("rst_sdata", bus.dfr_sample_data, 0);
        chk("rst_bdone", batch_done, 0);
        chk("rst_bcnt", batch_count, 0);
        chk("rst_flags", {overflow, underflow, timeout}, 0);

        // basic batch of 4
        enable = 1'b1;
        batch_len = 7'd4;
        for (int i = 0; i < 3; i++) push(16'hA000 + 16'(i));
        chk("t1_cnt3", bus.rx_sample_fifo_count, 3);
        tick();
        tick();
        chk("t1_nostart", bus.dfr_start, 0);
        chk("t1_idle", busy, 0);
        push(16'hA003);
        chk("t1_lat1", bus.dfr_start, 0);
        tick();
        chk("t1_lat2", bus.dfr_start, 1);
        chk("t1_busy", busy, 1);
        tick();
        bus.dfr_next_sample = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_svalid", bus.dfr_sample_valid, 1);
            chk("t1_sdata", bus.dfr_sample_data, 32'hA000 + i);
            tick();
        end
        chk("t1_exhaust", bus.dfr_sample_valid, 0);
        chk("t1_unf0", underflow, 0);
        tick();
        bus.dfr_next_sample = 1'b0;
        chk("t1_unf1", underflow, 1);
        chk("t1_cnt0", bus.rx_sample_fifo_count, 0);
        bus.dfr_done = 1'b1;
        tick();
        bus.dfr_done = 1'b0;
        chk("t1_bdone", batch_done, 1);
        tick();
        chk("t1_bcnt", batch_count, 1);
        chk("t1_bdone0", batch_done, 0);
        chk("t1_idle2", busy, 0);

        // latched length, early done, back-to-back restart
        for (int i = 0; i < 4; i++) push(16'hB000 + 16'(i));
        tick();
        chk("t2_start", bus.dfr_start, 1);
        tick();
        batch_len = 7'd1;
        bus.dfr_next_sample = 1'b1;
        chk("t2_d0", bus.dfr_sample_data, 32'hB000);
        tick();
        chk("t2_latched", bus.dfr_sample_valid, 1);
        chk("t2_d1", bus.dfr_sample_data, 32'hB001);
        tick();
        bus.dfr_next_sample = 1'b0;
        chk("t2_cnt2", bus.rx_sample_fifo_count, 2);
        bus.dfr_done = 1'b1;
        tick();
        bus.dfr_done = 1'b0;
        chk("t2_bdone", batch_done, 1);
        chk("t2_keep2", bus.rx_sample_fifo_count, 2);
        tick();
        chk("t2_restart", bus.dfr_start, 1);
        chk("t2_bcnt", batch_count, 2);
        tick();
        chk("t2_d2", bus.dfr_sample_data, 32'hB002);
        bus.dfr_next_sample = 1'b1;
        tick();
        bus.dfr_next_sample = 1'b0;
        chk("t2_l1_stop", bus.dfr_sample_valid, 0);
        chk("t2_cnt1", bus.rx_sample_fifo_count, 1);
        bus.dfr_done = 1'b1;
        enable = 1'b0;
        tick();
        bus.dfr_done = 1'b0;
        tick();
        chk("t2_bcnt3", batch_count, 3);

        // batch_len 0 clamps to 1
        batch_len = 7'd0;
        enable = 1'b1;
        tick();
        chk("t3_start", bus.dfr_start, 1);
        tick();
        chk("t3_d3", bus.dfr_sample_data, 32'hB003);
        bus.dfr_next_sample = 1'b1;
        tick();
        bus.dfr_next_sample = 1'b0;
        chk("t3_l1_stop", bus.dfr_sample_valid, 0);
        bus.dfr_done = 1'b1;
        enable = 1'b0;
        tick();
        bus.dfr_done = 1'b0;
        tick();
        chk("t3_bcnt4", batch_count, 4);
        chk("t3_idle", busy, 0);

        // overflow, batch_len 100 clamps to 64
        batch_len = 7'd100;
        for (int i = 0; i < 65; i++) push(16'hC000 + 16'(i));
        chk("t4_full", bus.rx_sample_fifo_wfull, 1);
        chk("t4_cnt64", bus.rx_sample_fifo_count, 64);
        chk("t4_ovf", overflow, 1);
        enable = 1'b1;
        tick();
        chk("t4_start", bus.dfr_start, 1);
        tick();
        bus.dfr_next_sample = 1'b1;
        for (int i = 0; i < 64; i++) begin
            chk("t4_sdata", bus.dfr_sample_data, 32'hC000 + i);
            tick();
        end
        bus.dfr_next_sample = 1'b0;
        chk("t4_no65", bus.dfr_sample_valid, 0);
        chk("t4_empty", bus.rx_sample_fifo_count, 0);
        push(16'hE000);
        push(16'hE001);
        chk("t4_cnt2", bus.rx_sample_fifo_count, 2);

        // reset in RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_busy", busy, 0);
        chk("rr_count", bus.rx_sample_fifo_count, 0);
        chk("rr_flags", {overflow, underflow, timeout}, 0);
        chk("rr_bcnt", batch_count, 0);

        // push and pop in the same cycle while full
        enable = 1'b0;
        for (int i = 0; i < 64; i++) push(16'hD000 + 16'(i));
        chk("t5_full", bus.rx_sample_fifo_wfull, 1);
        enable = 1'b1;
        tick();
        tick();
        chk("t5_d0", bus.dfr_sample_data, 32'hD000);
        bus.dfr_next_sample = 1'b1;
        bus.rx_sample_valid = 1'b1;
        bus.rx_sample_data  = 16'hBEEF;
        tick();
        bus.dfr_next_sample = 1'b0;
        bus.rx_sample_valid = 1'b0;
        chk("t5_cnt64", bus.rx_sample_fifo_count, 64);
        chk("t5_ovf0", overflow, 0);
        chk("t5_d1", bus.dfr_sample_data, 32'hD001);
        bus.dfr_done = 1'b1;
        tick();
        bus.dfr_done = 1'b0;
        chk("t5_bdone", batch_done, 1);
        tick();
        chk("t5_restart", bus.dfr_start, 1);
        tick();

        // watchdog
        n = 0;
        while (!batch_done && n < 300) begin
            tick();
            n++;
        end
`ifdef DFR_BATCH_TIMEOUT_EN
        chk("wd_cycles", n, TMO);
        chk("wd_tmo", timeout, 1);
`else
        chk("wd_none", n, 300);
        chk("wd_tmo0", timeout, 0);
        bus.dfr_done = 1'b1;
        tick();
        bus.dfr_done = 1'b0;
        chk("wd_bdone", batch_done, 1);
`endif
        tick();
        chk("wd_bcnt", batch_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
